button_cmd_scheduler: RTL and testbench
=======================================

Name: button_cmd_scheduler

Overview:
- Turns up to N_BTN raw front-panel buttons into a serialized command stream for the acquisition core.
- For each button, the block synchronizes the input, debounces it and detects the press edge, then latches the press as a pending request.
- A round-robin arbiter drains pending requests one at a time over a valid/ready handshake, so simultaneous presses are never lost and are never issued together.

Parameters:
- N_BTN, 4, number of buttons (>=2).
- SYNC_BITS, 2, synchronizer depth per button (>=2).
- DEB_COUNT, 256, consecutive differing samples required to change the debounced state (>=2).
- LONG_CYCLES, 65536, hold time in cycles that defines a long press (used only with LONG_PRESS_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_in  in  N_BTN  raw asynchronous buttons, active-high
- cmd_valid  out  1  command available
- cmd_ready  in  1  consumer accepts command
- cmd_id  out  $clog2(N_BTN)  index of button issued
- cmd_long  out  1  command is a long-press event
- pending  out  N_BTN  queued, not-yet-granted requests
- overrun  out  1  one-cycle pulse: press on an already-pending button
- busy  out  1  high when in ISSUE or when any pending bit is set

Behaviour:
- Reset (async assert, sync release): all outputs 0; sync chains 0; debounced states 0; counters 0; rr_ptr = N_BTN-1; state = IDLE.
- Synchronizer: SYNC_BITS-flop shift chain per bit; s = last stage.
- Debounce, per button:
  - cnt increments each cycle that s != deb; cnt clears to 0 when s == deb.
  - When s != deb and cnt == DEB_COUNT-1, deb toggles at the next edge and cnt clears.
  - A glitch shorter than DEB_COUNT cycles never changes deb.
- Press event: deb 0->1 registered at edge T sets pending[i] at edge T+1. Release produces no event.
- Coalescing: a press event while pending[i]=1 leaves pending[i]=1 and pulses overrun for 1 cycle.
- FSM IDLE:
  - If pending != 0, grant the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo N_BTN.
  - At the same edge: register cmd_id, set cmd_valid=1, clear pending[grant], set rr_ptr=grant, go to ISSUE.
  - cmd_valid is therefore high 1 cycle after pending[i] rises.
- FSM ISSUE:
  - cmd_valid=1; cmd_id and cmd_long are held stable.
  - On cmd_valid & cmd_ready: cmd_valid=0 and return to IDLE.
  - There is one mandatory idle cycle between consecutive commands.
- Simultaneous events:
  - Grant-clear and a new press event on the same bit in the same cycle: the set wins and pending stays 1.
  - Multiple buttons rising together are all queued and issued in round-robin order.
- cmd_ready while cmd_valid=0 is ignored. Stalling cmd_ready indefinitely is legal; presses keep queueing, one per button.
- Reset mid-transfer: cmd_valid drops immediately (async) and all queued requests are discarded.
- End-to-end latency from a clean btn_in rise to cmd_valid with the queue empty: SYNC_BITS + DEB_COUNT + 2 cycles, ±1 cycle of input sampling skew.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - Each button has a hold counter that counts while deb=1, saturates and clears when deb=0.
  - On reaching LONG_CYCLES-1 it raises a long event once per hold.
  - A long event sets pending[i] and long_pend[i]. Coalescing and overrun rules are identical to a normal press.
  - At grant, cmd_long takes long_pend[grant], which then clears.
  - A long press therefore produces two commands: a short one at press, then one with cmd_long=1.
- Undefined: no hold counters; cmd_long is tied to 0; LONG_CYCLES is unused.

Test Plan (N_BTN=4, SYNC_BITS=2, DEB_COUNT=4, LONG_CYCLES=16, cmd_ready=1 unless stated):
- Reset values: hold rst_n=0 with btn_in=4'hF -> all outputs 0. Release rst_n with btn_in=4'h0 -> no cmd_valid for 50 cycles.
- Single button: btn_in[2] rises cleanly -> cmd_valid high exactly at cycle 8 (±1) with cmd_id=2 and cmd_long=0, for one cycle; pending returns to 0.
- Glitch rejection: btn_in[1] high for 3 cycles, then low -> no pending, no cmd_valid. A 4-cycle-stable pulse -> one command, cmd_id=1.
- Round robin and backpressure: cmd_ready=0 and btn_in=4'hF together.
  - Expect cmd_valid with cmd_id=0 held; pending=4'hE.
  - Then raise cmd_ready: ids issue in order 0,1,2,3, with one idle cycle between each.
- Overrun: with cmd_ready=0 and button 0 pending, release and re-press btn_in[0] -> overrun pulses 1 cycle; pending[0] stays 1; only one command is issued for that button.
- LONG_PRESS_EN defined: hold btn_in[3] for 40 cycles -> two commands, cmd_id=3 with cmd_long=0, then cmd_id=3 with cmd_long=1. Assert rst_n=0 mid-ISSUE -> cmd_valid drops the same cycle.

Source files
------------

// File: rtl/button_cmd_scheduler.sv
// button_cmd_scheduler: front-panel button front end and command serializer.
// Each raw button input goes through a synchronizer, a debouncer and press-edge
// detection, and is then latched as a pending request. A round-robin arbiter
// issues the pending requests one at a time over a valid/ready handshake.
//
// Optional build macro: LONG_PRESS_EN
//   When defined, each button also has a hold counter. Holding a button raises a
//   second request that is flagged with cmd_long_o.
//   When undefined, cmd_long_o is tied low and LONG_CYCLES has no effect.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no command offered; grant the next pending request, if any
// ISSUE  | cmd_valid_o high; cmd_id_o/cmd_long_o held until accepted
module button_cmd_scheduler #(
    parameter int N_BTN       = 4,
    parameter int SYNC_BITS   = 2,
    parameter int DEB_COUNT   = 256,
    parameter int LONG_CYCLES = 65536
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_in_i,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [$clog2(N_BTN)-1:0] cmd_id_o,
    output logic                     cmd_long_o,
    output logic [N_BTN-1:0]         pending_o,
    output logic                     overrun_o,
    output logic                     busy_o
);

    localparam int ID_W  = $clog2(N_BTN);
    localparam int CNT_W = $clog2(DEB_COUNT);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_COUNT - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    logic [N_BTN-1:0] press_evt;
    logic [N_BTN-1:0] long_evt;
    logic [N_BTN-1:0] evt;

    // Per-button front end: synchronizer, debouncer, edge detect, hold timer.
    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        logic [SYNC_BITS-1:0] sync_q;
        logic                 s;
        logic                 deb_q, deb_d;
        logic                 deb_dly_q;
        logic [CNT_W-1:0]     cnt_q, cnt_d;

        // Shift the raw input through the synchronizer chain.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_BITS-2:0], btn_in_i[g]};
            end
        end

        assign s = sync_q[SYNC_BITS-1];

        // Count consecutive samples that differ from the debounced level.
        always_comb begin
            cnt_d = '0;
            deb_d = deb_q;
            if (s != deb_q) begin
                if (cnt_q == DEB_LAST) begin
                    deb_d = ~deb_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end

        // Debounced level, its delayed copy for edge detection, and the counter.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_q     <= 1'b0;
                deb_dly_q <= 1'b0;
                cnt_q     <= '0;
            end else begin
                deb_q     <= deb_d;
                deb_dly_q <= deb_q;
                cnt_q     <= cnt_d;
            end
        end

        // Only the rising debounced edge is an event; release is ignored.
        assign press_evt[g] = deb_q & ~deb_dly_q;

`ifdef LONG_PRESS_EN
        localparam int HOLD_W = $clog2(LONG_CYCLES);
        localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
        localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);

        logic [HOLD_W-1:0] hold_q, hold_d;

        // Hold timer runs while the button is down and parks at its last value.
        always_comb begin
            hold_d = '0;
            if (deb_q) begin
                hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + HOLD_W'(1);
            end
        end

        // Hold timer register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q <= '0;
            end else begin
                hold_q <= hold_d;
            end
        end

        // Fires exactly once per hold, on the step into the saturated value.
        assign long_evt[g] = deb_q & (hold_q == HOLD_PRE);
`else
        assign long_evt[g] = 1'b0;
`endif
    end

    assign evt = press_evt | long_evt;

    state_t            state_q, state_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [ID_W-1:0]   cmd_id_q, cmd_id_d;
    logic              cmd_long_q, cmd_long_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_BTN-1:0]  pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic [N_BTN-1:0]  grant_clr;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [N_BTN-1:0]  long_pend_q;

    // Round-robin search: first pending bit after the last granted index.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= N_BTN; k++) begin
            int idx;
            idx = (int'(rr_ptr_q) + k) % N_BTN;
            if (!grant_found && pending_q[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    // Issue FSM next-state and command register updates.
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_id_d    = cmd_id_q;
        cmd_long_d  = cmd_long_q;
        rr_ptr_d    = rr_ptr_q;
        grant_clr   = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d              = S_ISSUE;
                    cmd_valid_d          = 1'b1;
                    cmd_id_d             = grant_idx;
                    rr_ptr_d             = grant_idx;
                    grant_clr[grant_idx] = 1'b1;
`ifdef LONG_PRESS_EN
                    cmd_long_d           = long_pend_q[grant_idx];
`else
                    cmd_long_d           = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                if (cmd_ready_i) begin
                    state_d     = S_IDLE;
                    cmd_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    // Pending queue: a new event outranks a grant clear on the same bit.
    always_comb begin
        pending_d = (pending_q & ~grant_clr) | evt;
        overrun_d = |(evt & pending_q);
    end

    // FSM, command and queue registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_id_q    <= '0;
            cmd_long_q  <= 1'b0;
            rr_ptr_q    <= ID_W'(N_BTN - 1);
            pending_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_id_q    <= cmd_id_d;
            cmd_long_q  <= cmd_long_d;
            rr_ptr_q    <= rr_ptr_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef LONG_PRESS_EN
    // Long-press flags ride alongside the pending bits and clear at grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_pend_q <= '0;
        end else begin
            long_pend_q <= (long_pend_q & ~grant_clr) | long_evt;
        end
    end
`else
    assign long_pend_q = '0;
`endif

    assign cmd_valid_o = cmd_valid_q;
    assign cmd_id_o    = cmd_id_q;
    assign cmd_long_o  = cmd_long_q;
    assign pending_o   = pending_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q == S_ISSUE) | (|pending_q);

endmodule

// File: tb/tb_button_cmd_scheduler.sv
// Self-checking bench for button_cmd_scheduler with a small debounce window.
module tb_button_cmd_scheduler;

    localparam int N_BTN       = 4;
    localparam int SYNC_BITS   = 2;
    localparam int DEB_COUNT   = 4;
    localparam int LONG_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn = 4'h0;
    logic       ready = 1'b1;
    logic       cmd_valid;
    logic [1:0] cmd_id;
    logic       cmd_long;
    logic [3:0] pending;
    logic       overrun;
    logic       busy;

    int total  = 0;
    int passed = 0;

    button_cmd_scheduler #(
        .N_BTN(N_BTN), .SYNC_BITS(SYNC_BITS),
        .DEB_COUNT(DEB_COUNT), .LONG_CYCLES(LONG_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in_i(btn),
        .cmd_valid_o(cmd_valid), .cmd_ready_i(ready),
        .cmd_id_o(cmd_id), .cmd_long_o(cmd_long),
        .pending_o(pending), .overrun_o(overrun), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int btn;
        int width;
        int exp_cmds;
        int exp_id;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act >= lo && act <= hi) passed++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        btn   = 4'h0;
        ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input string name);
        int ok;
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            if (cmd_valid) begin
                ok = 1;
                break;
            end
            tick();
        end
        chk(name, ok, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncmd, lat, id, lng, pend, ov;
        int ids[4];
        int lngs[4];

        vecs[0] = '{btn: 2, width: 10, exp_cmds: 1, exp_id: 2};
        vecs[1] = '{btn: 1, width: 3,  exp_cmds: 0, exp_id: 0};
        vecs[2] = '{btn: 1, width: 4,  exp_cmds: 1, exp_id: 1};
        vecs[3] = '{btn: 0, width: 6,  exp_cmds: 1, exp_id: 0};
        vecs[4] = '{btn: 3, width: 2,  exp_cmds: 0, exp_id: 0};

        // Reset values with all buttons high.
        rst_n = 1'b0;
        btn   = 4'hF;
        repeat (3) tick();
        chk("rst_valid",   int'(cmd_valid), 0);
        chk("rst_id",      int'(cmd_id),    0);
        chk("rst_long",    int'(cmd_long),  0);
        chk("rst_pending", int'(pending),   0);
        chk("rst_overrun", int'(overrun),   0);
        chk("rst_busy",    int'(busy),      0);
        btn   = 4'h0;
        rst_n = 1'b1;
        ncmd  = 0;
        repeat (50) begin
            tick();
            if (cmd_valid) ncmd++;
        end
        chk("idle_after_rst", ncmd, 0);

        // Single-button pulses of several widths.
        for (int v = 0; v < 5; v++) begin
            ncmd = 0; lat = -1; id = -1; lng = -1; pend = -1;
            btn[vecs[v].btn] = 1'b1;
            for (int c = 1; c <= 30; c++) begin
                tick();
                if (c == vecs[v].width) btn[vecs[v].btn] = 1'b0;
                if (cmd_valid) begin
                    ncmd++;
                    if (lat < 0) begin
                        lat = c; id = int'(cmd_id); lng = int'(cmd_long); pend = int'(pending);
                    end
                end
            end
            chk($sformatf("vec%0d_cmds", v), ncmd, vecs[v].exp_cmds);
            if (ncmd > 0) begin
                chk_rng($sformatf("vec%0d_latency", v), lat,
                        SYNC_BITS + DEB_COUNT + 1, SYNC_BITS + DEB_COUNT + 3);
                chk($sformatf("vec%0d_id", v), id, vecs[v].exp_id);
                chk($sformatf("vec%0d_long", v), lng, 0);
                chk($sformatf("vec%0d_pending", v), pend, 0);
            end
        end

        // Round robin under backpressure.
        do_reset();
        ready = 1'b0;
        btn   = 4'hF;
        wait_valid("rr_first_valid");
        repeat (5) tick();
        chk("rr_hold_valid",   int'(cmd_valid), 1);
        chk("rr_hold_id",      int'(cmd_id),    0);
        chk("rr_hold_pending", int'(pending),   14);
        chk("rr_hold_busy",    int'(busy),      1);
        ready = 1'b1;
        btn   = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("rr_valid_k%0d", k), int'(cmd_valid), (k % 2 == 0 && k <= 6) ? 1 : 0);
            if (cmd_valid) chk($sformatf("rr_id_k%0d", k), int'(cmd_id), k / 2);
        end
        chk("rr_pending_done", int'(pending), 0);

        // Overrun: re-press a button that is already queued.
        do_reset();
        ready  = 1'b0;
        btn[0] = 1'b1;
        wait_valid("ov_first_valid");
        chk("ov_first_id", int'(cmd_id), 0);
        repeat (2) tick();
        btn[0] = 1'b0;
        repeat (8) tick();
        btn[0] = 1'b1;
        ov = 0;
        repeat (8) begin
            tick();
            ov += int'(overrun);
        end
        chk("ov_none_first", ov, 0);
        chk("ov_pending_first", int'(pending), 1);
        btn[0] = 1'b0;
        repeat (8) tick();
        btn[0] = 1'b1;
        ov = 0;
        repeat (8) begin
            tick();
            ov += int'(overrun);
        end
        chk("ov_pulse", ov, 1);
        chk("ov_pending_kept", int'(pending), 1);
        ready  = 1'b1;
        btn[0] = 1'b0;
        ncmd = 0; id = -1;
        repeat (20) begin
            tick();
            if (cmd_valid) begin
                ncmd++;
                id = int'(cmd_id);
            end
        end
        chk("ov_cmds_after", ncmd, 1);
        chk("ov_id_after", id, 0);

`ifdef LONG_PRESS_EN
        // Long hold yields a short then a long command.
        do_reset();
        btn[3] = 1'b1;
        ncmd = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 40) btn[3] = 1'b0;
            if (cmd_valid) begin
                if (ncmd < 4) begin
                    ids[ncmd]  = int'(cmd_id);
                    lngs[ncmd] = int'(cmd_long);
                end
                ncmd++;
            end
        end
        chk("long_cmds", ncmd, 2);
        if (ncmd >= 2) begin
            chk("long_id0",   ids[0],  3);
            chk("long_flag0", lngs[0], 0);
            chk("long_id1",   ids[1],  3);
            chk("long_flag1", lngs[1], 1);
        end
`endif

        // Reset asserted while a command is being offered.
        do_reset();
        ready = 1'b0;
        btn   = 4'b0110;
        wait_valid("mid_valid");
        tick();
        chk("mid_id", int'(cmd_id), 1);
        chk("mid_pending", int'(pending), 4);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",   int'(cmd_valid), 0);
        chk("mid_rst_pending", int'(pending),   0);
        chk("mid_rst_busy",    int'(busy),      0);
        btn = 4'h0;
        tick();
        rst_n = 1'b1;
        ncmd = 0;
        repeat (20) begin
            tick();
            if (cmd_valid) ncmd++;
        end
        chk("mid_discarded", ncmd, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
